// File: rtl/mul_share_pkg.sv
// mul_share_pkg
// Shared definitions for the multiplier-sharing arbiter: controller state
// encoding and the default operand widths and watchdog limit.
// Ports: none (package).
// Build option: MUL_ZERO_BYPASS_EN (used by mul_share_arbiter).

package mul_share_pkg;

  localparam int DEFAULT_NREQ    = 4;
  localparam int DEFAULT_M       = 8;
  localparam int DEFAULT_N       = 8;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin picker. Searches upward from the requester after
// i_lastGrant, wrapping around, and returns the first active request.
// The priority pointer itself lives in the parent.
// Ports:
//   i_req       NREQ  request vector
//   i_lastGrant IDW   index of the most recently served requester
//   i_enable    1     when low, no grant is produced
//   o_grant     NREQ  one-hot grant (or zero)
//   o_grantIdx  IDW   encoded index of the grant (0 when none)

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_lastGrant,
  input  logic            i_enable,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grantIdx
);

  logic           w_found;
  logic [IDW-1:0] w_cand;

  // Walk the candidates in rotated priority order; the first hit wins and
  // masks everything behind it.
  always_comb begin
    o_grant    = '0;
    o_grantIdx = '0;
    w_found    = 1'b0;
    w_cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(i_lastGrant) + k) % NREQ);
      if (i_enable && !w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_grantIdx      = w_cand;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// Shares one multi-cycle unsigned multiplier between NREQ requesters.
// Requests are accepted round-robin, one at a time; the operands are held on
// mul_d/mul_q, a one-cycle mul_start is issued, and the product is returned
// tagged with the requester ID. A watchdog turns a missing mul_done into an
// error response so a hung multiplier cannot stall the block.
// Ports:
//   clk, rst                      clock, async active-low reset
//   req_valid/req_ready           per-requester operand handshake
//   req_d/req_q                   packed operands, requester i at [i*M +: M]
//   mul_start/mul_d/mul_q         multiplier command
//   mul_done/mul_product          multiplier completion
//   rsp_valid/rsp_ready           response handshake
//   rsp_id/rsp_product/rsp_err    response payload (err = watchdog timeout)
// Build option: MUL_ZERO_BYPASS_EN -- a zero operand skips the multiplier and
// answers 0 one cycle after the handshake.

module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ    = DEFAULT_NREQ,
  parameter int M       = DEFAULT_M,
  parameter int N       = DEFAULT_N,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*M-1:0] req_d,
  input  logic [NREQ*N-1:0] req_q,
  output logic              mul_start,
  output logic [M-1:0]      mul_d,
  output logic [N-1:0]      mul_q,
  input  logic              mul_done,
  input  logic [M+N-1:0]    mul_product,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [M+N-1:0]    rsp_product,
  output logic              rsp_err
);

  localparam int WDW = $clog2(TIMEOUT);

  state_t           r_state;
  state_t           w_nextState;
  logic [IDW-1:0]   r_lastGrant;
  logic [WDW-1:0]   r_wdog;
  logic [M-1:0]     r_mulD;
  logic [N-1:0]     r_mulQ;
  logic [IDW-1:0]   r_rspId;
  logic [M+N-1:0]   r_rspProduct;
  logic             r_rspErr;

  logic             w_arbEnable;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grantIdx;
  logic             w_hsFire;
  logic             w_timeout;
  logic [M-1:0]     w_dSel;
  logic [N-1:0]     w_qSel;
  logic             w_bypass;

  // The arbiter only runs in IDLE; gating with rst keeps req_ready at 0
  // while reset is held even though IDLE is the reset state.
  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req       (req_valid),
    .i_lastGrant (r_lastGrant),
    .i_enable    (w_arbEnable),
    .o_grant     (w_grant),
    .o_grantIdx  (w_grantIdx)
  );

  assign w_hsFire  = |w_grant;
  assign w_dSel    = req_d[int'(w_grantIdx)*M +: M];
  assign w_qSel    = req_q[int'(w_grantIdx)*N +: N];
  assign w_timeout = (r_wdog == WDW'(TIMEOUT - 1));

`ifdef MUL_ZERO_BYPASS_EN
  assign w_bypass = (w_dSel == '0) || (w_qSel == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign req_ready   = w_grant;
  assign mul_d       = r_mulD;
  assign mul_q       = r_mulQ;
  assign rsp_id      = r_rspId;
  assign rsp_product = r_rspProduct;
  assign rsp_err     = r_rspErr;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // Next-state and control decode. mul_done outside WAIT is simply not
  // looked at, so stray pulses fall away. In WAIT, done is tested before the
  // watchdog so a simultaneous done still produces a good result.
  always_comb begin
    w_nextState = r_state;
    w_arbEnable = 1'b0;
    mul_start   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        w_arbEnable = rst;
        if (w_hsFire) w_nextState = w_bypass ? RESP : ISSUE;
      end
      ISSUE: begin
        mul_start   = 1'b1;
        w_nextState = WAIT;
      end
      WAIT: begin
        if (mul_done || w_timeout) w_nextState = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: operand capture at the handshake, watchdog, result capture and
  // the round-robin pointer, which only advances once the response is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lastGrant  <= IDW'(NREQ - 1);
      r_wdog       <= '0;
      r_mulD       <= '0;
      r_mulQ       <= '0;
      r_rspId      <= '0;
      r_rspProduct <= '0;
      r_rspErr     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hsFire) begin
            r_mulD  <= w_dSel;
            r_mulQ  <= w_qSel;
            r_rspId <= w_grantIdx;
            if (w_bypass) begin
              r_rspProduct <= '0;
              r_rspErr     <= 1'b0;
            end
          end
        end
        ISSUE: r_wdog <= '0;
        WAIT: begin
          if (mul_done) begin
            r_rspProduct <= mul_product;
            r_rspErr     <= 1'b0;
          end else if (w_timeout) begin
            r_rspProduct <= '0;
            r_rspErr     <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WDW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) r_lastGrant <= r_rspId;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
// Directed bench for mul_share_arbiter with a behavioural multiplier model,
// a round-robin grant predictor and a scoreboard of expected responses.
// Honours MUL_ZERO_BYPASS_EN for the zero-operand expectations.

module tb_mul_share_arbiter;

  localparam int NREQ    = 4;
  localparam int M       = 8;
  localparam int N       = 8;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 64;
  localparam int P       = M + N;

  typedef struct {
    logic [IDW-1:0] id;
    logic [P-1:0]   prod;
    logic           err;
    int             lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*M-1:0] req_d;
  logic [NREQ*N-1:0] req_q;
  logic              mul_start;
  logic [M-1:0]      mul_d;
  logic [N-1:0]      mul_q;
  logic              mul_done;
  logic [P-1:0]      mul_product;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [P-1:0]      rsp_product;
  logic              rsp_err;

  logic [M-1:0] dArr [NREQ];
  logic [N-1:0] qArr [NREQ];

  exp_t           sb[$];
  int             total = 0;
  int             bad = 0;
  int             edgeCnt = 0;
  int             hsEdge = 0;
  int             hsCount = 0;
  int             modelLast = NREQ - 1;
  int             dropIdx = -1;
  logic           tbBusy = 1'b0;
  logic           autoDrop = 1'b1;
  logic [NREQ-1:0] lastReady = '0;
  logic           prevValid = 1'b0;
  logic [IDW-1:0] prevId;
  logic [P-1:0]   prevProd;
  logic           prevErr;

  int           modelLat = 18;
  logic         hang = 1'b0;
  logic         forceDone = 1'b0;
  int           cnt;
  logic         modelDone;
  logic [P-1:0] modelProd;
  int           startCount = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_d[i*M +: M] = dArr[i];
      req_q[i*N +: N] = qArr[i];
    end
  end

  // Behavioural multiplier: done is high for the cycle sampled modelLat+1
  // edges after the edge that sees mul_start. In hang mode it never answers.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 0;
      modelDone <= 1'b0;
    end else begin
      modelDone <= 1'b0;
      if (mul_start) begin
        startCount <= startCount + 1;
        if (!hang) begin
          cnt       <= modelLat;
          modelProd <= P'(mul_d) * P'(mul_q);
        end
      end else if (cnt > 1) begin
        cnt <= cnt - 1;
      end else if (cnt == 1) begin
        modelDone <= 1'b1;
        cnt       <= 0;
      end
    end
  end

  assign mul_done    = modelDone | forceDone;
  assign mul_product = modelProd;

  mul_share_arbiter #(
    .NREQ    (NREQ),
    .M       (M),
    .N       (N),
    .IDW     (IDW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_d       (req_d),
    .req_q       (req_q),
    .mul_start   (mul_start),
    .mul_d       (mul_d),
    .mul_q       (mul_q),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err)
  );

  // Expected winner: first valid requester after 'last', with wrap-around.
  function automatic logic [NREQ-1:0] rrPredict(input logic [NREQ-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (v[idx[IDW-1:0]]) return NREQ'(1) << idx;
    end
    return '0;
  endfunction

  function automatic int onehotIdx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [M-1:0] d, input logic [N-1:0] q);
    dArr[id]      = d;
    qArr[id]      = q;
    req_valid[id] = 1'b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    checkOutput({tag, "_mul_start"}, 32'(mul_start), 32'(0));
    checkOutput({tag, "_mul_d"}, 32'(mul_d), 32'(0));
    checkOutput({tag, "_mul_q"}, 32'(mul_q), 32'(0));
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    checkOutput({tag, "_rsp_id"}, 32'(rsp_id), 32'(0));
    checkOutput({tag, "_rsp_product"}, 32'(rsp_product), 32'(0));
    checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'(0));
  endtask

  // One clock cycle. Called at a negedge after inputs are set; samples just
  // after that, predicts the handshake of the coming edge, checks any
  // response, then advances to the next negedge.
  task automatic step();
    logic [NREQ-1:0] expReady;
    exp_t e;
    int w;
    #1;
    if (rst) begin
      expReady = tbBusy ? '0 : rrPredict(req_valid, modelLast);
      checkOutput("req_ready", 32'(req_ready), 32'(expReady));
      if (expReady != '0) begin
        w      = onehotIdx(expReady);
        e.id   = IDW'(w);
        e.err  = hang;
        e.prod = hang ? '0 : P'(dArr[w]) * P'(qArr[w]);
        e.lat  = hang ? TIMEOUT + 1 : modelLat + 2;
`ifdef MUL_ZERO_BYPASS_EN
        if (dArr[w] == '0 || qArr[w] == '0) begin
          e.err  = 1'b0;
          e.prod = '0;
          e.lat  = 1;
        end
`endif
        sb.push_back(e);
        tbBusy    = 1'b1;
        hsEdge    = edgeCnt;
        hsCount   = hsCount + 1;
        lastReady = req_ready;
        if (autoDrop) dropIdx = w;
      end
      if (rsp_valid === 1'b1) begin
        checkOutput("rsp_expected", 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
          if (!prevValid) begin
            checkOutput("latency", 32'(edgeCnt - 1 - hsEdge), 32'(sb[0].lat));
          end else begin
            checkOutput("hold_id", 32'(rsp_id), 32'(prevId));
            checkOutput("hold_product", 32'(rsp_product), 32'(prevProd));
            checkOutput("hold_err", 32'(rsp_err), 32'(prevErr));
          end
          if (rsp_ready) begin
            e = sb.pop_front();
            checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
            checkOutput("rsp_product", 32'(rsp_product), 32'(e.prod));
            checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
            tbBusy    = 1'b0;
            modelLast = int'(e.id);
          end
        end
      end
      prevValid = rsp_valid & ~rsp_ready;
      prevId    = rsp_id;
      prevProd  = rsp_product;
      prevErr   = rsp_err;
    end else begin
      prevValid = 1'b0;
    end
    @(negedge clk);
    if (dropIdx >= 0) begin
      req_valid[dropIdx] = 1'b0;
      dropIdx = -1;
    end
  endtask

  task automatic drain(input int maxCyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxCyc) begin
      step();
      n++;
    end
    checkOutput("drain_done", 32'(sb.size()), 32'(0));
  endtask

  task automatic waitHandshake(input int maxCyc);
    int n;
    int h0;
    n  = 0;
    h0 = hsCount;
    while (hsCount == h0 && n < maxCyc) begin
      step();
      n++;
    end
    checkOutput("handshake_seen", 32'(hsCount != h0), 32'(1));
  endtask

  task automatic waitRespValid(input int maxCyc);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < maxCyc) begin
      step();
      n++;
    end
    checkOutput("rsp_valid_seen", 32'(rsp_valid), 32'(1));
  endtask

  // Safety net in case a wait slips past its own bound.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int s0;
    int h0;
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      dArr[i] = '0;
      qArr[i] = '0;
    end
    #1 rst = 1'b0;
    req_valid = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    #1 checkResetOutputs("por");
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    step();
    step();

    // 1. single request from requester 2
    $display("[TB] single request");
    s0 = startCount;
    applyStimulus(2, 8'd13, 8'd11);
    step();
    drain(100);
    checkOutput("t1_starts", 32'(startCount - s0), 32'(1));

    // 2. fairness; requester 2 was served last, so the rotation starts at 3
    $display("[TB] fairness");
    autoDrop = 1'b0;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, M'(i + 3), N'(i + 5));
    for (int k = 0; k < 8; k++) begin
      waitHandshake(100);
      checkOutput("t2_order", 32'(lastReady), 32'(NREQ'(1) << ((3 + k) % NREQ)));
    end
    req_valid = '0;
    autoDrop  = 1'b1;
    drain(100);

    // 3. backpressure with a competing request waiting
    $display("[TB] backpressure");
    applyStimulus(1, 8'd200, 8'd3);
    step();
    rsp_ready = 1'b0;
    applyStimulus(0, 8'd7, 8'd9);
    waitRespValid(100);
    for (int k = 0; k < 10; k++) begin
      checkOutput("t3_valid_held", 32'(rsp_valid), 32'(1));
      step();
    end
    rsp_ready = 1'b1;
    h0 = hsCount;
    step();
    step();
    checkOutput("t3_next_grant", 32'(hsCount - h0), 32'(1));
    drain(100);

    // 4. boundary operands
    $display("[TB] boundary values");
    applyStimulus(3, 8'd255, 8'd255);
    step();
    drain(100);
    s0 = startCount;
    applyStimulus(2, 8'd0, 8'd77);
    step();
    drain(100);
`ifdef MUL_ZERO_BYPASS_EN
    checkOutput("t4_zero_starts", 32'(startCount - s0), 32'(0));
`else
    checkOutput("t4_zero_starts", 32'(startCount - s0), 32'(1));
`endif

    // 5. watchdog, then a stray done in IDLE
    $display("[TB] watchdog");
    hang = 1'b1;
    applyStimulus(0, 8'd5, 8'd6);
    step();
    drain(TIMEOUT + 20);
    hang = 1'b0;
    forceDone = 1'b1;
    step();
    forceDone = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("t5_no_stray", 32'(rsp_valid), 32'(0));
      step();
    end

    // 6. reset while the multiplier is busy
    $display("[TB] reset mid-operation");
    applyStimulus(2, 8'd9, 8'd9);
    step();
    for (int k = 0; k < 5; k++) step();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, M'(i + 1), N'(2));
    #2 rst = 1'b0;
    #1 checkResetOutputs("midrst");
    sb.delete();
    tbBusy    = 1'b0;
    modelLast = NREQ - 1;
    prevValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    waitHandshake(5);
    checkOutput("t6_first_grant", 32'(lastReady), 32'(1));
    req_valid = '0;
    drain(100);
    for (int k = 0; k < 25; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
